mod_n_counter: RTL

Parametrised modulo-N up/down counter with enable, synchronous load, wrap/saturate mode and terminal-count flags. It is the general-purpose successor to the fixed 2-bit enable counter. The wrap target is configurable, so the legacy 0→1→2→3→1 sequence is one parameter setting. Used as a tick/prescale and event counter feeding FSMs elsewhere in the design.

---
 rtl/counter_pkg.sv | 9 +
 rtl/mod_n_counter.sv | 114 +++++++++++
 2 files changed

// File: rtl/counter_pkg.sv
// Shared encodings for the modulo-N counter: mode and direction values.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

endpackage : counter_pkg

// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter over the range [WRAP_VAL, MAX_VAL] with
// synchronous load, wrap or saturate behaviour at the terminals, a sticky
// DONE flag for saturation, and a free-running count of wrap events.
//
// Handshake: there is no valid/ready pair. EN and LOAD are level inputs
// sampled on every rising clk edge; LOAD has priority over EN, and rst
// overrides both asynchronously.
module mod_n_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_VAL   = 9,
  parameter int WRAP_VAL  = 0,
  parameter int RESET_VAL = 0,
  parameter int WCW       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  input  logic             UP,
  input  logic             MODE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] COUNT,
  output logic             MAX,
  output logic             MIN,
  output logic             DONE,
  output logic [WCW-1:0]   WRAP_CNT
);

  // Reject illegal parameter combinations at elaboration time.
  if ((WIDTH < 1) || (WCW < 1) || (MAX_VAL >= (1 << WIDTH)) ||
      (WRAP_VAL < 0) || (WRAP_VAL > MAX_VAL) ||
      (RESET_VAL < 0) || (RESET_VAL > MAX_VAL)) begin : g_bad_params
    $error("mod_n_counter: illegal parameters (need WRAP_VAL <= MAX_VAL < 2**WIDTH, RESET_VAL <= MAX_VAL)");
  end

  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] WRAP_C  = WIDTH'(WRAP_VAL);
  localparam logic [WIDTH-1:0] RESET_C = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic [WCW-1:0]   wrap_cnt_q, wrap_cnt_d;

  logic             at_max;
  logic             at_min;
  logic [WIDTH-1:0] load_clamped;
  logic             max_flag;
  logic             min_flag;

  // Next-state for count, done and wrap counter, plus the terminal flags.
  // Counts below WRAP_VAL are treated as already at the lower terminal, so
  // counting down from them wraps (or saturates) rather than underflowing.
  always_comb begin
    count_d      = count_q;
    done_d       = done_q;
    wrap_cnt_d   = wrap_cnt_q;
    at_max       = (count_q == MAX_C);
    at_min       = (count_q <= WRAP_C);
    load_clamped = (LOAD_VAL > MAX_C) ? MAX_C : LOAD_VAL;
    max_flag     = ~rst & EN & (UP == DIR_UP) & at_max;
    min_flag     = ~rst & EN & (UP == DIR_DOWN) & at_min;

    if (LOAD) begin
      count_d = load_clamped;
      done_d  = 1'b0;
    end else if (EN && !done_q) begin
      if (UP == DIR_UP) begin
        if (at_max) begin
          if (MODE == MODE_SAT) begin
            done_d = 1'b1;
          end else begin
            count_d    = WRAP_C;
            wrap_cnt_d = wrap_cnt_q + WCW'(1);
          end
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (at_min) begin
          if (MODE == MODE_SAT) begin
            done_d = 1'b1;
          end else begin
            count_d    = MAX_C;
            wrap_cnt_d = wrap_cnt_q + WCW'(1);
          end
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  // Register count, done and wrap counter; asynchronous reset to start state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= RESET_C;
      done_q     <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      count_q    <= count_d;
      done_q     <= done_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign COUNT    = count_q;
  assign DONE     = done_q;
  assign WRAP_CNT = wrap_cnt_q;
  assign MAX      = max_flag;
  assign MIN      = min_flag;

endmodule : mod_n_counter
